// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: add/sub class in 1 cycle, shift-add multiply in WIDTH+1, shifts in shamt+1 (latency from accept).
// Backpressure: result and flag are held in DONE until out_ready; only one operation is in flight at a time.
module alu_seq_unit #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               cout,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t                 state_q;
    logic [2:0]             op_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2*WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]       mplier_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]       sh_q;
    logic                   sign_q;
    logic [WIDTH-1:0]       result_q;
    logic                   cout_q;

    logic [WIDTH-1:0]       b_eff;
    logic                   c_eff;
    logic [WIDTH:0]         sum_d;
    logic [2*WIDTH-1:0]     acc_d;
    logic [WIDTH-1:0]       sh_d;
    logic                   sh_out_d;
    logic                   last_step;

    // op[0] selects subtract (invert b); op[1] selects the external carry instead of the implicit one.
    assign b_eff = op[0] ? ~b : b;
    assign c_eff = op[1] ? cin : op[0];
    assign sum_d = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};

    assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign last_step = (cnt_q == CNT_W'(1));

    always_comb begin
        sh_d     = sh_q;
        sh_out_d = 1'b0;
        case (op_q)
            OP_SHL: begin
                sh_d     = {sh_q[WIDTH-2:0], 1'b0};
                sh_out_d = sh_q[WIDTH-1];
            end
            OP_SHR: begin
                sh_d     = {1'b0, sh_q[WIDTH-1:1]};
                sh_out_d = sh_q[0];
            end
            default: begin
                sh_d     = {sign_q, sh_q[WIDTH-1:1]};
                sh_out_d = sh_q[0];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= op;
                        if (!op[2]) begin
                            result_q <= sum_d[WIDTH-1:0];
                            cout_q   <= sum_d[WIDTH];
                            state_q  <= S_DONE;
                        end else if (op == OP_MUL) begin
                            mcand_q  <= {{WIDTH{1'b0}}, a};
                            mplier_q <= b;
                            acc_q    <= '0;
                            cnt_q    <= CNT_W'(WIDTH);
                            state_q  <= S_EXEC;
                        end else begin
                            sh_q   <= a;
                            sign_q <= a[WIDTH-1];
                            if (shamt == '0) begin
                                result_q <= a;
                                cout_q   <= 1'b0;
                                state_q  <= S_DONE;
                            end else begin
                                cnt_q   <= CNT_W'(shamt);
                                state_q <= S_EXEC;
                            end
                        end
                    end
                end
                S_EXEC: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (op_q == OP_MUL) begin
                        acc_q    <= acc_d;
                        mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                        mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                        if (last_step) begin
                            result_q <= acc_d[WIDTH-1:0];
                            cout_q   <= |acc_d[2*WIDTH-1:WIDTH];
                            state_q  <= S_DONE;
                        end
                    end else begin
                        sh_q <= sh_d;
                        if (last_step) begin
                            result_q <= sh_d;
                            cout_q   <= sh_out_d;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed literal cases plus randomized ops scored against a behavioural model.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  shamt;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] r;
        logic        c;
        int          lat;
        int          t0;
        bit          seen;
    } exp_t;
    exp_t exp_q[$];

    alu_seq_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .shamt(shamt), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Returns {cout, result} straight from the arithmetic definition of each op.
    function automatic logic [16:0] model(input logic [2:0] o, input logic [15:0] x,
                                          input logic [15:0] y, input logic [3:0] s,
                                          input logic ci);
        logic [16:0] ext_x, ext_y, ext_ny, ext_c;
        logic [31:0] p;
        logic [15:0] r;
        logic        c;
        int          k;
        ext_x  = {1'b0, x};
        ext_y  = {1'b0, y};
        ext_ny = {1'b0, ~y};
        ext_c  = {16'd0, ci};
        k      = int'(s) - 1;
        case (o)
            3'd0: return ext_x + ext_y;
            3'd1: return ext_x + ext_ny + 17'd1;
            3'd2: return ext_x + ext_y + ext_c;
            3'd3: return ext_x + ext_ny + ext_c;
            3'd4: begin
                p = {16'd0, x} * {16'd0, y};
                return {|p[31:16], p[15:0]};
            end
            3'd5: begin
                p = {16'd0, x} << s;
                return {(s != 4'd0) ? p[16] : 1'b0, p[15:0]};
            end
            3'd6: begin
                r = x >> s;
                c = (s != 4'd0) ? x[k] : 1'b0;
                return {c, r};
            end
            default: begin
                r = $signed(x) >>> s;
                c = (s != 4'd0) ? x[k] : 1'b0;
                return {c, r};
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [3:0] s);
        if (o < 3'd4) return 1;
        if (o == 3'd4) return 17;
        return int'(s) + 1;
    endfunction

    // Single compare process: scoreboard every accepted op and check outputs on every cycle.
    always @(negedge clk) begin
        logic [16:0] m;
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~in_ready});
            if (out_valid) begin
                chk("ready_in_done", {31'd0, in_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    chk("sb_result", {16'd0, result}, {16'd0, exp_q[0].r});
                    chk("sb_cout", {31'd0, cout}, {31'd0, exp_q[0].c});
                    if (!exp_q[0].seen) begin
                        chk("sb_latency", 32'(cyc - exp_q[0].t0), 32'(exp_q[0].lat));
                        exp_q[0].seen = 1'b1;
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                m      = model(op, a, b, shamt, cin);
                e.r    = m[15:0];
                e.c    = m[16];
                e.lat  = model_lat(op, shamt);
                e.t0   = cyc;
                e.seen = 1'b0;
                exp_q.push_back(e);
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [3:0] s, input logic ci);
        op = o; a = x; b = y; shamt = s; cin = ci;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
        shamt = 4'($urandom); cin = 1'($urandom);
    endtask

    task automatic collect(input int hold, output logic [15:0] r, output logic c, output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("valid_seen", {31'd0, out_valid}, 32'd1);
        r = result;
        c = cout;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_result", {16'd0, result}, {16'd0, r});
        end
        // in_valid stays high across the release edge: it must not be taken in the same cycle.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("back_to_idle", {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    task automatic run_lit(input string name, input logic [2:0] o, input logic [15:0] x,
                           input logic [15:0] y, input logic [3:0] s, input logic ci,
                           input logic [15:0] er, input logic ec, input int elat, input int hold);
        logic [15:0] r;
        logic        c;
        int          lat;
        send(o, x, y, s, ci);
        collect(hold, r, c, lat);
        chk({name, "_res"}, {16'd0, r}, {16'd0, er});
        chk({name, "_cout"}, {31'd0, c}, {31'd0, ec});
        chk({name, "_lat"}, 32'(lat), 32'(elat));
        chk({name, "_model"}, {15'd0, model(o, x, y, s, ci)}, {15'd0, ec, er});
    endtask

    initial begin
        logic [15:0] r;
        logic        c;
        int          lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; shamt = '0; cin = 1'b0;
        #2;
        chk("reset_outputs", {14'd0, in_ready, out_valid, result, cout, busy}, {14'd0, 2'b10, 16'd0, 2'b00});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_lit("add_wrap",  3'd0, 16'hFFFF, 16'h0001, 4'd0, 1'b0, 16'h0000, 1'b1, 1, 0);
        run_lit("adc",       3'd2, 16'hFFFF, 16'h0001, 4'd0, 1'b1, 16'h0001, 1'b1, 1, 0);
        run_lit("sub_borrow",3'd1, 16'h0005, 16'h0007, 4'd0, 1'b0, 16'hFFFE, 1'b0, 1, 0);
        run_lit("sub_ok",    3'd1, 16'h0007, 16'h0005, 4'd0, 1'b0, 16'h0002, 1'b1, 1, 0);
        run_lit("sbc",       3'd3, 16'h0007, 16'h0005, 4'd0, 1'b0, 16'h0001, 1'b1, 1, 0);
        run_lit("mul_small", 3'd4, 16'h0003, 16'h0005, 4'd0, 1'b0, 16'h000F, 1'b0, 17, 0);
        run_lit("mul_ovf",   3'd4, 16'h0100, 16'h0100, 4'd0, 1'b0, 16'h0000, 1'b1, 17, 0);
        run_lit("mul_zero",  3'd4, 16'h1234, 16'h0000, 4'd0, 1'b0, 16'h0000, 1'b0, 17, 0);
        run_lit("asr3",      3'd7, 16'h8000, 16'h0000, 4'd3, 1'b0, 16'hF000, 1'b0, 4, 0);
        run_lit("shl1",      3'd5, 16'h8001, 16'h0000, 4'd1, 1'b0, 16'h0002, 1'b1, 2, 0);
        run_lit("shr0",      3'd6, 16'hABCD, 16'h0000, 4'd0, 1'b1, 16'hABCD, 1'b0, 1, 0);
        run_lit("shr15",     3'd6, 16'hC000, 16'h0000, 4'd15, 1'b0, 16'h0001, 1'b1, 16, 0);
        run_lit("asr15",     3'd7, 16'h8000, 16'h0000, 4'd15, 1'b0, 16'hFFFF, 1'b0, 16, 0);
        run_lit("held",      3'd0, 16'h1234, 16'h1111, 4'd0, 1'b0, 16'h2345, 1'b0, 1, 5);
        run_lit("after_held",3'd1, 16'h0010, 16'h0001, 4'd0, 1'b0, 16'h000F, 1'b1, 1, 0);

        // Reset during the 8th multiply step abandons the operation.
        send(3'd4, 16'h0003, 16'h0005, 4'd0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        chk("busy_mid_mul", {30'd0, busy, out_valid}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {14'd0, in_ready, out_valid, result, cout, busy}, {14'd0, 2'b10, 16'd0, 2'b00});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("idle_after_rst", {30'd0, in_ready, out_valid}, 32'd2);
        run_lit("add_after_rst", 3'd0, 16'h0002, 16'h0003, 4'd0, 1'b0, 16'h0005, 1'b0, 1, 0);

        for (int i = 0; i < 250; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            send(3'($urandom), 16'($urandom), (i % 7 == 0) ? 16'd0 : 16'($urandom),
                 4'($urandom), 1'($urandom));
            collect(int'($urandom_range(0, 3)), r, c, lat);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
